// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit: multi-cycle RV32M MUL/MULH*/DIV*/REM* execute unit.          |
// | Optional MULDIV_FAST_MUL_EN: single-cycle product, straight to FIX.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int C_CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [C_CNT_W-1:0]    r_count;
    logic [2:0]            r_funct3;
    logic [XLEN-1:0]       r_a;
    logic [XLEN-1:0]       r_b;
    logic                  r_neg_main;
    logic                  r_neg_rem;
    logic [2*XLEN-1:0]     r_prod;
    logic [XLEN-1:0]       r_result;

    logic                  w_a_signed;
    logic                  w_b_signed;
    logic                  w_sa;
    logic                  w_sb;
    logic [XLEN-1:0]       w_mag_a;
    logic [XLEN-1:0]       w_mag_b;
    logic                  w_div0;
    logic                  w_ovf;
    logic                  w_special;
    logic [XLEN-1:0]       w_special_res;
    logic                  w_fast_mul;
    logic                  w_accept;
    logic [2*XLEN-1:0]     w_prod_init;
    logic [XLEN:0]         w_mul_sum;
    logic [2*XLEN-1:0]     w_mul_step;
    logic [XLEN:0]         w_div_sh;
    logic [XLEN:0]         w_div_diff;
    logic [2*XLEN-1:0]     w_div_step;
    logic [2*XLEN-1:0]     w_prod_s;
    logic [XLEN-1:0]       w_quo_s;
    logic [XLEN-1:0]       w_rem_s;
    logic [XLEN-1:0]       w_fix_res;

    // Operand decode: only MULHU/DIVU/REMU (odd funct3 with bit1|bit2) treat rs1 as unsigned.
    assign w_a_signed = ~(funct3_i[0] & (funct3_i[1] | funct3_i[2]));
    assign w_b_signed = w_a_signed & (funct3_i != 3'b010);
    assign w_sa       = w_a_signed & rs1_i[XLEN-1];
    assign w_sb       = w_b_signed & rs2_i[XLEN-1];
    assign w_mag_a    = w_sa ? -rs1_i : rs1_i;
    assign w_mag_b    = w_sb ? -rs2_i : rs2_i;

    assign w_div0     = funct3_i[2] & (rs2_i == '0);
    assign w_ovf      = funct3_i[2] & ~funct3_i[0] &
                        (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
    assign w_special  = w_div0 | w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = funct3_i[1] ? rs1_i : '1;
        else if (w_ovf)
            w_special_res = funct3_i[1] ? '0 : rs1_i;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
    assign w_fast_mul  = ~funct3_i[2];
    assign w_prod_init = funct3_i[2] ? {{XLEN{1'b0}}, w_mag_a} : w_fast_prod;
`else
    assign w_fast_mul  = 1'b0;
    assign w_prod_init = funct3_i[2] ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
`endif

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) & start_i & ~flush_i;

    // Shift-add: upper half accumulates multiplicand, multiplier drains out of the low half.
    assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
    assign w_mul_step = {w_mul_sum, r_prod[XLEN-1:1]};

    // Restoring divide: {remainder, quotient} share r_prod and shift left together.
    assign w_div_sh   = r_prod[2*XLEN-1:XLEN-1];
    assign w_div_diff = w_div_sh - {1'b0, r_b};
    assign w_div_step = w_div_diff[XLEN] ? {w_div_sh[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};

    assign w_prod_s = r_neg_main ? -r_prod : r_prod;
    assign w_quo_s  = r_neg_main ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
    assign w_rem_s  = r_neg_rem  ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = '0;
        case (r_funct3)
            3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo_s;
            default:                w_fix_res = w_rem_s;
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    w_next = S_IDLE;
                    if (start_i)
                        w_next = w_special ? S_DONE : (w_fast_mul ? S_FIX : S_CALC);
                end
                S_CALC:  w_next = (r_count == '0) ? S_FIX : S_CALC;
                S_FIX:   w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count    <= '0;
            r_funct3   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_prod     <= '0;
            r_result   <= '0;
        end else if (w_accept) begin
            r_count    <= C_CNT_W'(XLEN-1);
            r_funct3   <= funct3_i;
            r_a        <= w_mag_a;
            r_b        <= w_mag_b;
            r_neg_main <= w_sa ^ w_sb;
            r_neg_rem  <= w_sa;
            r_prod     <= w_prod_init;
            if (w_special)
                r_result <= w_special_res;
        end else if (r_state == S_CALC && !flush_i) begin
            r_prod <= r_funct3[2] ? w_div_step : w_mul_step;
            if (r_count != '0)
                r_count <= r_count - C_CNT_W'(1);
        end else if (r_state == S_FIX && !flush_i) begin
            r_result <= w_fix_res;
        end
    end

    assign busy_o   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_unit: randomized bench for muldiv_unit against an arithmetic    |
// | reference model. Rev 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    muldiv_unit #(.XLEN(XLEN)) u_dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] pu;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        pu  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 0;
        r   = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
            3'd3: r = pu[63:32];
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0)) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 2;
`endif
        return XLEN + 2;
    endfunction

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        start_i  = 1'b1;
        @(posedge clk_i); #1;
        start_i  = 1'b0;
    endtask

    // Called one cycle after the accepting edge; optionally pulses a stray start at cycle poke_at.
    task automatic wait_done(input string tag, input int lat, input logic [31:0] exp, input int poke_at);
        int k;
        int nbusy;
        bit seen;
        k = 1; nbusy = 0; seen = 1'b0;
        while (k <= 100 && !seen) begin
            if (done_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy_o === 1'b1) nbusy++;
                if (poke_at > 0) begin
                    start_i = (k == poke_at);
                    if (k == poke_at) begin
                        rs1_i    = $urandom;
                        rs2_i    = $urandom;
                        funct3_i = 3'($urandom);
                    end
                end
                @(posedge clk_i); #1;
                k++;
            end
        end
        if (poke_at > 0) start_i = 1'b0;
        check_val({tag, " done"}, 32'(seen), 32'd1);
        check_val({tag, " lat"},  32'(k), 32'(lat));
        check_val({tag, " busy"}, 32'(nbusy), 32'(lat - 1));
        check_val({tag, " res"},  result_o, exp);
    endtask

    task automatic run_dir(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        launch(f3, a, b);
        wait_done(tag, ref_lat(f3, a, b), exp, 0);
    endtask

    initial begin
        logic [2:0]  f3, f3b;
        logic [31:0] a, b, a2, b2, prev;
        int          poke;

        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = '0; rs1_i = '0; rs2_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst busy", 32'(busy_o), 32'd0);
        check_val("rst done", 32'(done_o), 32'd0);
        check_val("rst res",  result_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_dir("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_dir("mulh",   3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);
        run_dir("mulhsu", 3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_dir("mulhu",  3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF);
        run_dir("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_dir("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_dir("divu",   3'd5, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF);
        run_dir("div0",   3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF);
        run_dir("remu0",  3'd7, 32'd5,          32'd0,         32'd5);
        run_dir("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_dir("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        run_dir("rem0",   3'd6, 32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            poke = (i % 5 == 0 && ref_lat(f3, a, b) > 4) ? 3 : 0;
            launch(f3, a, b);
            wait_done($sformatf("rand%0d f%0d", i, f3), ref_lat(f3, a, b), ref_op(f3, a, b), poke);
        end

        // Back-to-back with start held high; op2 operands sit on the bus during op1.
        f3 = 3'd5; a = 32'd1000; b = 32'd7;
        f3b = 3'd6; a2 = 32'hFFFF_FC18; b2 = 32'd7;
        funct3_i = f3; rs1_i = a; rs2_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        funct3_i = f3b; rs1_i = a2; rs2_i = b2;
        wait_done("b2b op1", ref_lat(f3, a, b), ref_op(f3, a, b), 0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wait_done("b2b op2", ref_lat(f3b, a2, b2), ref_op(f3b, a2, b2), 0);
        prev = ref_op(f3b, a2, b2);

        // Flush a DIV at cycle T+10: no done, result retained, next op normal.
        launch(3'd4, 32'd99999, 32'd13);
        repeat (9) begin @(posedge clk_i); #1; end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check_val("flush busy", 32'(busy_o), 32'd0);
        begin
            bit any_done;
            any_done = done_o;
            repeat (40) begin
                @(posedge clk_i); #1;
                any_done = any_done | done_o;
            end
            check_val("flush nodone", 32'(any_done), 32'd0);
        end
        check_val("flush res", result_o, prev);
        run_dir("postflush", 3'd6, 32'd100, 32'd7, 32'd2);

        // Reset while iterating clears all outputs.
        launch(3'd5, 32'd5000, 32'd3);
        repeat (4) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_val("midrst busy", 32'(busy_o), 32'd0);
        check_val("midrst done", 32'(done_o), 32'd0);
        check_val("midrst res",  result_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        run_dir("postrst", 3'd0, 32'd12, 32'd12, 32'd144);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
